// File: rtl/pwm_multi_core_if.sv
// MMIO slot bus for pwm_multi_core: select, strobes, address and data.
interface pwm_multi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM slot core: shared prescaler/period counter, edge or center
// alignment, double-buffered duty/top. Optional register readback: PWM_READBACK_EN.
module pwm_multi_core #(
  parameter int OUT_PORTS = 8,
  parameter int RES       = 16,
  parameter int DVSR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_multi_core_if.slave      bus,
  output logic [OUT_PORTS-1:0] pwm_out,
  output logic                 period_tick
);

  localparam logic [4:0] NCH = 5'(OUT_PORTS);

  logic [DVSR_W-1:0]    dvsr;
  logic [DVSR_W-1:0]    dvsr_ctr;
  logic [RES-1:0]       top_shadow;
  logic [RES-1:0]       top_active;
  logic [RES-1:0]       cnt;
  logic                 dir;
  logic                 enable;
  logic                 mode;
  logic [OUT_PORTS-1:0] pol;
  logic [OUT_PORTS-1:0] ch_en;
  logic [RES:0]         duty_shadow [OUT_PORTS];
  logic [RES:0]         duty_active [OUT_PORTS];

  logic wr_en, wr_ctrl, wr_duty, tick, top_zero, boundary;

  assign wr_en    = bus.cs && bus.write;
  assign wr_ctrl  = wr_en && (bus.reg_addr == 5'h02);
  assign wr_duty  = wr_en && bus.reg_addr[4] && ({1'b0, bus.reg_addr[3:0]} < NCH);
  assign tick     = enable && (dvsr_ctr == dvsr);
  assign top_zero = (top_active == '0);
  assign boundary = tick && (top_zero || (mode ? (dir && cnt == '0) : (cnt == top_active)));

  // Register file (shadow side)
  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr       <= '0;
      top_shadow <= RES'(255);
      enable     <= 1'b0;
      mode       <= 1'b0;
      pol        <= '0;
      ch_en      <= '0;
      for (int unsigned i = 0; i < OUT_PORTS; i++) duty_shadow[i] <= '0;
    end else begin
      if (wr_en && bus.reg_addr == 5'h00) dvsr       <= bus.wr_data[DVSR_W-1:0];
      if (wr_en && bus.reg_addr == 5'h01) top_shadow <= bus.wr_data[RES-1:0];
      if (wr_ctrl) begin
        enable <= bus.wr_data[0];
        mode   <= bus.wr_data[1];
      end
      if (wr_en && bus.reg_addr == 5'h03) pol   <= bus.wr_data[OUT_PORTS-1:0];
      if (wr_en && bus.reg_addr == 5'h04) ch_en <= bus.wr_data[OUT_PORTS-1:0];
      for (int unsigned i = 0; i < OUT_PORTS; i++)
        if (wr_duty && bus.reg_addr[3:0] == 4'(i)) duty_shadow[i] <= bus.wr_data[RES:0];
    end
  end

  // Active copies follow shadows while idle; otherwise reload only at a boundary,
  // so a same-cycle shadow write lands one period later.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_active <= RES'(255);
      for (int unsigned i = 0; i < OUT_PORTS; i++) duty_active[i] <= '0;
    end else if (!enable || boundary) begin
      top_active <= top_shadow;
      for (int unsigned i = 0; i < OUT_PORTS; i++) duty_active[i] <= duty_shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || wr_ctrl || !enable) begin
      dvsr_ctr <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
    end else begin
      dvsr_ctr <= tick ? '0 : dvsr_ctr + 1'b1;
      if (tick) begin
        if (top_zero) begin
          cnt <= '0;
          dir <= 1'b0;
        end else if (!mode) begin
          cnt <= (cnt == top_active) ? '0 : cnt + 1'b1;
        end else if (!dir) begin
          if (cnt == top_active) begin
            dir <= 1'b1;
            cnt <= top_active - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          if (cnt == '0) begin
            dir <= 1'b0;
            cnt <= RES'(1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < OUT_PORTS; i++)
        pwm_out[i] <= (({1'b0, cnt} < duty_active[i]) & ch_en[i] & enable) ^ pol[i];
      period_tick <= boundary;
    end
  end

`ifdef PWM_READBACK_EN
  always_comb begin
    bus.rd_data = '0;
    if (bus.cs && bus.read) begin
      case (bus.reg_addr)
        5'h00: bus.rd_data[DVSR_W-1:0]    = dvsr;
        5'h01: bus.rd_data[RES-1:0]       = top_shadow;
        5'h02: bus.rd_data[1:0]           = {mode, enable};
        5'h03: bus.rd_data[OUT_PORTS-1:0] = pol;
        5'h04: bus.rd_data[OUT_PORTS-1:0] = ch_en;
        5'h05: begin
          bus.rd_data[31]      = dir;
          bus.rd_data[RES-1:0] = cnt;
        end
        default: begin
          for (int unsigned i = 0; i < OUT_PORTS; i++)
            if (bus.reg_addr == 5'(16 + i)) bus.rd_data[RES:0] = duty_shadow[i];
        end
      endcase
    end
  end
`else
  assign bus.rd_data = '0;
`endif

endmodule

// File: tb/tb_pwm_multi_core.sv
// Directed bench for pwm_multi_core: table of steady-state waveform configs plus
// shadowing, polarity/enable, reset and readback sequences.
module tb_pwm_multi_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pwm_out;
  logic       period_tick;

  always #5 clk = ~clk;

  pwm_multi_core_if bus ();

  pwm_multi_core #(.OUT_PORTS(8), .RES(16), .DVSR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  typedef struct {
    logic [31:0] dvsr;
    logic [15:0] top;
    logic        mode;
    logic [16:0] duty;
    logic [7:0]  pol;
    logic [7:0]  ch_en;
    int          exp_high;
    int          exp_period;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.read = 1'b1; bus.reg_addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic configure(input vec_t v);
    wr(5'h02, 32'd0);
    wr(5'h00, v.dvsr);
    wr(5'h01, {16'd0, v.top});
    wr(5'h10, {15'd0, v.duty});
    wr(5'h03, {24'd0, v.pol});
    wr(5'h04, {24'd0, v.ch_en});
    wr(5'h02, {30'd0, v.mode, 1'b1});
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (!period_tick && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, period_tick, 1);
  endtask

  // Counts pwm_out[0] highs over one period, starting just after a period tick.
  task automatic measure(input int period, output int high, output int tick_pos,
                         output int nticks);
    high = 0; tick_pos = -1; nticks = 0;
    for (int j = 1; j <= period; j++) begin
      @(negedge clk);
      if (pwm_out[0]) high++;
      if (period_tick) begin
        nticks++;
        tick_pos = j;
      end
    end
  endtask

  task automatic count_ch1(input int n, output int ones);
    ones = 0;
    repeat (25) @(negedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (pwm_out[1]) ones++;
    end
  endtask

  vec_t        vecs [10];
  vec_t        v;
  int          high, tpos, nt, h1, h2, t1, t2, ones, n;
  logic [31:0] d;
  string       nm;

  initial begin
    vecs[0] = '{32'd0, 16'd9, 1'b0, 17'd3,  8'h0, 8'h1, 3,  10};
    vecs[1] = '{32'd0, 16'd4, 1'b1, 17'd2,  8'h0, 8'h1, 3,  8};
    vecs[2] = '{32'd2, 16'd9, 1'b0, 17'd3,  8'h0, 8'h1, 9,  30};
    vecs[3] = '{32'd0, 16'd9, 1'b0, 17'd0,  8'h0, 8'h1, 0,  10};
    vecs[4] = '{32'd0, 16'd9, 1'b0, 17'd10, 8'h0, 8'h1, 10, 10};
    vecs[5] = '{32'd0, 16'd9, 1'b0, 17'd3,  8'h1, 8'h1, 7,  10};
    vecs[6] = '{32'd0, 16'd9, 1'b0, 17'd3,  8'h0, 8'h0, 0,  10};
    vecs[7] = '{32'd0, 16'd4, 1'b1, 17'd5,  8'h0, 8'h1, 8,  8};
    vecs[8] = '{32'd0, 16'd1, 1'b1, 17'd1,  8'h0, 8'h1, 1,  2};
    vecs[9] = '{32'd1, 16'd0, 1'b0, 17'd1,  8'h0, 8'h1, 2,  2};

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.reg_addr = '0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_tick", period_tick, 0);
`ifdef PWM_READBACK_EN
    rd(5'h01, d); check("reset_top_read", d, 32'hFF);
`endif
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      configure(vecs[i]);
      $sformat(nm, "vec%0d_tick_wait", i);
      wait_tick(nm);
      measure(vecs[i].exp_period, high, tpos, nt);
      $sformat(nm, "vec%0d_high", i);     check(nm, high, vecs[i].exp_high);
      $sformat(nm, "vec%0d_tick_pos", i); check(nm, tpos, vecs[i].exp_period);
      $sformat(nm, "vec%0d_tick_cnt", i); check(nm, nt, 1);
    end

    // Duty shadow written mid-period, then top shadow written mid-period.
    configure(vecs[0]);
    wait_tick("shadow_tick_wait");
    h1 = 0; h2 = 0; t1 = -1;
    for (int j = 1; j <= 20; j++) begin
      if (j == 6) begin
        bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = 5'h10; bus.wr_data = 32'd6;
      end
      @(negedge clk);
      bus.cs = 1'b0; bus.write = 1'b0;
      if (pwm_out[0]) begin
        if (j <= 10) h1++; else h2++;
      end
      if (period_tick) t1 = j;
    end
    check("shadow_duty_old_period", h1, 3);
    check("shadow_duty_new_period", h2, 6);
    check("shadow_duty_tick", t1, 20);
    h2 = 0; t1 = -1; t2 = -1;
    for (int j = 1; j <= 30; j++) begin
      if (j == 5) begin
        bus.cs = 1'b1; bus.write = 1'b1; bus.reg_addr = 5'h01; bus.wr_data = 32'd19;
      end
      @(negedge clk);
      bus.cs = 1'b0; bus.write = 1'b0;
      if (j > 10 && pwm_out[0]) h2++;
      if (period_tick) begin
        if (t1 < 0) t1 = j; else t2 = j;
      end
    end
    check("shadow_top_first_tick", t1, 10);
    check("shadow_top_second_tick", t2, 30);
    check("shadow_top_high", h2, 6);

    // Polarity and channel enable on channel 1.
    v = vecs[0];
    v.pol = 8'h2;
    configure(v);
    count_ch1(20, ones); check("ch1_disabled_idle", ones, 20);
    wr(5'h04, 32'h3);
    wr(5'h11, 32'd0);
    count_ch1(20, ones); check("ch1_duty0_inverted", ones, 20);
    wr(5'h11, 32'd10);
    count_ch1(20, ones); check("ch1_full_inverted", ones, 0);

    // Reset while the output is high.
    configure(vecs[2]);
    n = 0;
    while (!pwm_out[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("prereset_high", pwm_out[0], 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_pwm_out", pwm_out, 0);
    check("midreset_period_tick", period_tick, 0);
`ifdef PWM_READBACK_EN
    rd(5'h01, d); check("midreset_top_read", d, 32'hFF);
    rd(5'h00, d); check("midreset_dvsr_read", d, 0);
    rd(5'h02, d); check("midreset_ctrl_read", d, 0);
    rd(5'h10, d); check("midreset_duty0_read", d, 0);
    rd(5'h05, d); check("midreset_status_read", d, 0);
`else
    rd(5'h01, d); check("midreset_rd_tied", d, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef PWM_READBACK_EN
    wr(5'h13, 32'h1234);
    rd(5'h13, d); check("rb_duty3", d, 32'h1234);
    @(negedge clk);
    wr(5'h1A, 32'h5555);
    rd(5'h1A, d); check("rb_unmapped_chan", d, 0);
    rd(5'h13, d); check("rb_duty3_unchanged", d, 32'h1234);
    @(negedge clk);
    wr(5'h01, 32'h000ABCDE);
    rd(5'h01, d); check("rb_top_trunc", d, 32'hBCDE);
    @(negedge clk);
    wr(5'h12, 32'hFFFFFFFF);
    rd(5'h12, d); check("rb_duty_trunc", d, 32'h1FFFF);
    @(negedge clk);
    configure(vecs[1]);
    wait_tick("status_tick_wait");
    n = 0; high = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      rd(5'h05, d);
      if (d[31]) n++;
      if (d[15:0] > high[15:0]) high = int'(d[15:0]);
    end
    check("status_dir_down_cnt", n, 4);
    check("status_cnt_max", high, 4);
`else
    wr(5'h01, 32'h1234);
    rd(5'h01, d); check("rd_tied_zero", d, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_core.md
Name: pwm_multi_core

Overview:
- Second-generation PWM slot core for the MicroBlaze MMIO bus.
- Drives up to 16 PWM channels from one shared prescaler and period counter.
- Adds over the first-generation core:
  - programmable period top, instead of a fixed 2^RES wrap;
  - edge-aligned and center-aligned modes;
  - per-channel polarity and per-channel enable;
  - double-buffered (glitch-free) duty/top updates;
  - a period-end pulse.

Parameters:
- OUT_PORTS, 8, number of PWM channels (1..16).
- RES, 16, counter/top width in bits. Duty registers are RES+1 bits so 100% is reachable.
- DVSR_W, 32, prescaler register width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  slot select
- read  in  1  bus read strobe
- write  in  1  bus write strobe
- reg_addr  in  5  register address
- wr_data  in  32  write data
- rd_data  out  32  read data
- pwm_out  out  OUT_PORTS  registered PWM outputs
- period_tick  out  1  one-clock pulse at each period boundary

Behaviour:
- Reset: already decided as reset reset, synchronous, active-high; clock clk. All state registers clear to 0, except top_shadow and top_active, which reset to 0xFF. pwm_out=0, period_tick=0, dir=up.
- Register map (write when cs&&write). Writes take wr_data truncated to the register width:
  - 0x00 dvsr (DVSR_W bits).
  - 0x01 top_shadow (RES bits).
  - 0x02 ctrl: bit0 global enable, bit1 mode (0 edge, 1 center). Any write to ctrl clears dvsr_ctr and cnt and sets dir=up.
  - 0x03 polarity mask (OUT_PORTS bits; 1 = inverted).
  - 0x04 channel enable mask.
  - 0x05 status, read-only: bit31 dir (1=down), bits[RES-1:0] cnt.
  - 0x10+X duty_shadow[X] (RES+1 bits). Writes with X>=OUT_PORTS are ignored.
- Prescaler:
  - dvsr_ctr counts 0..dvsr, then wraps to 0. tick = (dvsr_ctr==dvsr). dvsr=0 gives a tick every clock.
  - While global enable=0, dvsr_ctr, cnt and dir are held at 0 / up.
- Edge mode, on tick: cnt = (cnt==top_active) ? 0 : cnt+1.
  - Boundary = tick && cnt==top_active.
  - Period = (dvsr+1)*(top+1) clocks.
- Center mode, on tick:
  - Up: if cnt==top_active, dir<=down and cnt<=top-1; else cnt+1.
  - Down: if cnt==0, dir<=up and cnt<=1; else cnt-1.
  - Boundary = tick && dir==down && cnt==0.
  - Period = 2*top ticks.
- top_active=0 (either mode): cnt held at 0, dir stays up, every tick is a boundary.
- Shadowing:
  - At a boundary, duty_active[] and top_active load from their shadows.
  - While global enable=0, active registers track their shadows every clock.
  - A shadow write in the same cycle as a boundary: the active register loads the pre-write value; the new value applies at the next boundary.
- Compare: raw[i] = ({1'b0,cnt} < duty_active[i]).
  - duty=0 gives constant inactive.
  - duty>=top+1 gives constant active.
- Output: pwm_out[i] <= (raw[i] & ch_en[i] & enable) ^ pol[i].
  - One clock latency from cnt to pin.
  - Disabled channels sit at their idle level, pol[i].
- period_tick: registered copy of the boundary, high one clock, only while enabled.
- Reset mid-period: outputs are 0 on the next clock and the counter restarts from 0.

Optional Feature:
- Macro: PWM_READBACK_EN.
- Defined: when cs&&read, rd_data is a combinational mux by reg_addr.
  - Returns the shadow values for dvsr/top/duty, plus ctrl/pol/ch_en/status.
  - Unmapped addresses and channels X>=OUT_PORTS return 0.
- Undefined: rd_data tied to 32'h0 and no status register (register-compatible with the first-generation core).

Test Plan:
1. Edge, dvsr=0, top=9, duty0=3, ch_en=1, ctrl=1 -> pwm_out[0] high 3 clk / low 7 clk, repeating every 10 clk; period_tick every 10 clk.
2. Center, dvsr=0, top=4, duty0=2, ctrl=3 -> period 8 clk; pwm_out[0] high 3 contiguous clk (cnt 1,0,1) centred on cnt=0; status dir toggles at cnt=4.
3. Shadow: edge, top=9, write duty0 3->6 at cnt=5 -> rest of the current period keeps the 3-high pattern; the next period is 6 high. Write top=19 mid-period -> the new 20-tick period starts after the current boundary.
4. Polarity/enable: pol=0x2 with ch_en[1]=0 -> pwm_out[1]=1 constant. ch_en[1]=1, duty1=0 -> constant 1. duty1=10 (top 9) -> constant 0.
5. Prescale/reset: dvsr=2, top=9 -> period 30 clk, duty0=3 high 9 clk. Assert reset mid-period -> pwm_out=0 next clk; with PWM_READBACK_EN, reads of 0x01 return 0xFF and all others 0.
6. Readback (PWM_READBACK_EN): write 0x13 with OUT_PORTS=8 -> read returns the value. Write/read 0x1A -> read returns 0 and no channel changes.
